// File: rtl/frv_dmem_arbiter.sv
// Two-master arbiter for the core data memory port: m0 priority, lock held across stalls.
// Define FRV_DMEM_ARB_FAIR_EN to enable the m1 anti-starvation counter (limit WAIT_LIMIT).
module frv_dmem_arbiter #(
  parameter int WAIT_LIMIT = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        m0_cen,
  input  logic        m0_wen,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_stall,
  output logic        m0_error,
  output logic [31:0] m0_rdata,
  input  logic        m1_cen,
  input  logic        m1_wen,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_stall,
  output logic        m1_error,
  output logic [31:0] m1_rdata,
  output logic        dmem_cen,
  output logic        dmem_wen,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_stall,
  input  logic        dmem_error,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  arb_owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  owner_t owner_reg;
  owner_t owner_next;
  logic   grant0;
  logic   grant1;
  logic   starve;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      owner_reg <= OWN_NONE;
    end else begin
      owner_reg <= owner_next;
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the port.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    owner_next = owner_reg;
    if (g_resetn) begin
      case (owner_reg)
        OWN_NONE: begin
          if (starve && m1_cen) begin
            grant1 = 1'b1;
          end else if (m0_cen) begin
            grant0 = 1'b1;
          end else if (m1_cen) begin
            grant1 = 1'b1;
          end
          if (grant0 && dmem_stall) begin
            owner_next = OWN_M0;
          end else if (grant1 && dmem_stall) begin
            owner_next = OWN_M1;
          end
        end
        OWN_M0: begin
          grant0 = m0_cen;
          if (!m0_cen || !dmem_stall) begin
            owner_next = OWN_NONE;
          end
        end
        OWN_M1: begin
          grant1 = m1_cen;
          if (!m1_cen || !dmem_stall) begin
            owner_next = OWN_NONE;
          end
        end
        default: owner_next = OWN_NONE;
      endcase
    end
  end

  always_comb begin
    dmem_cen   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_strb  = 4'h0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    if (grant0) begin
      dmem_cen   = 1'b1;
      dmem_wen   = m0_wen;
      dmem_strb  = m0_strb;
      dmem_addr  = m0_addr;
      dmem_wdata = m0_wdata;
    end else if (grant1) begin
      dmem_cen   = 1'b1;
      dmem_wen   = m1_wen;
      dmem_strb  = m1_strb;
      dmem_addr  = m1_addr;
      dmem_wdata = m1_wdata;
    end
  end

  assign m0_stall  = grant0 ? dmem_stall : m0_cen;
  assign m1_stall  = grant1 ? dmem_stall : m1_cen;
  assign m0_error  = grant0 & dmem_error;
  assign m1_error  = grant1 & dmem_error;
  assign m0_rdata  = dmem_rdata;
  assign m1_rdata  = dmem_rdata;
  assign arb_owner = owner_reg;

`ifdef FRV_DMEM_ARB_FAIR_EN
  localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;

  // Counts m0 completions that overtook a waiting m1; saturates at the limit.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!m1_cen || (grant1 && !dmem_stall)) begin
      wait_cnt_next = 4'd0;
    end else if (grant0 && !dmem_stall && (wait_cnt_reg != LIMIT)) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wait_cnt_reg <= 4'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign starve = (wait_cnt_reg == LIMIT);
`else
  // WAIT_LIMIT is inert without fair mode; strict m0 priority.
  assign starve = 1'b0 & (WAIT_LIMIT > 0);
`endif

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Directed bench for frv_dmem_arbiter with a per-master scoreboard of expected completions.
module tb_frv_dmem_arbiter;

  localparam int WL = 4;
`ifdef FRV_DMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        g_clk;
  logic        g_resetn;
  logic        m0_cen, m0_wen, m1_cen, m1_wen;
  logic [3:0]  m0_strb, m1_strb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_stall, m0_error, m1_stall, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dmem_cen, dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_stall, dmem_error;
  logic [31:0] dmem_rdata;
  logic [1:0]  arb_owner;

  typedef struct {
    logic [31:0] addr;
    logic        err;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   checks = 0;
  int   errors = 0;

  frv_dmem_arbiter #(.WAIT_LIMIT(WL)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_cen(m0_cen), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_stall(m0_stall), .m0_error(m0_error), .m0_rdata(m0_rdata),
    .m1_cen(m1_cen), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_stall(m1_stall), .m1_error(m1_error), .m1_rdata(m1_rdata),
    .dmem_cen(dmem_cen), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_stall(dmem_stall), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata), .arb_owner(arb_owner)
  );

  // Memory responder: read data is a fixed function of the forwarded address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  assign dmem_rdata = mem_rd(dmem_addr);

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [31:0] a, input logic e);
    txn_t t;
    t.addr = a;
    t.err  = e;
    q0.push_back(t);
  endtask

  task automatic push1(input logic [31:0] a, input logic e);
    txn_t t;
    t.addr = a;
    t.err  = e;
    q1.push_back(t);
  endtask

  task automatic monitor();
    txn_t t;
    if (m0_cen && !m0_stall) begin
      if (q0.size() == 0) begin
        chk("m0_unexpected_done", 32'(q0.size()), 32'd1);
      end else begin
        t = q0.pop_front();
        $display("m0 done addr=%h rdata=%h err=%b", dmem_addr, m0_rdata, m0_error);
        chk("m0_addr", dmem_addr, t.addr);
        chk("m0_rdata", m0_rdata, mem_rd(t.addr));
        chk("m0_err", 32'(m0_error), 32'(t.err));
      end
    end
    if (m1_cen && !m1_stall) begin
      if (q1.size() == 0) begin
        chk("m1_unexpected_done", 32'(q1.size()), 32'd1);
      end else begin
        t = q1.pop_front();
        $display("m1 done addr=%h rdata=%h err=%b", dmem_addr, m1_rdata, m1_error);
        chk("m1_addr", dmem_addr, t.addr);
        chk("m1_rdata", m1_rdata, mem_rd(t.addr));
        chk("m1_err", 32'(m1_error), 32'(t.err));
      end
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    monitor();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic        m1_pend;
    logic        m0_fresh;
    logic        exp_m1;

    g_resetn = 1'b0;
    m0_cen = 1'b1; m0_wen = 1'b0; m0_strb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_cen = 1'b1; m1_wen = 1'b0; m1_strb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    dmem_stall = 1'b0; dmem_error = 1'b1;

    // Reset held: nothing forwarded, requesters see stall, no error.
    #3;
    chk("rst_owner", 32'(arb_owner), 32'd0);
    chk("rst_dmem_cen", 32'(dmem_cen), 32'd0);
    chk("rst_m0_stall", 32'(m0_stall), 32'd1);
    chk("rst_m1_stall", 32'(m1_stall), 32'd1);
    chk("rst_m0_err", 32'(m0_error), 32'd0);
    chk("rst_m1_err", 32'(m1_error), 32'd0);
    tick();
    m0_cen = 1'b0; m1_cen = 1'b0; dmem_error = 1'b0;
    g_resetn = 1'b1;
    tick();

    // Uncontended single-cycle m0 read.
    m0_cen = 1'b1; m0_addr = 32'h100; push0(32'h100, 1'b0);
    settle();
    chk("unc_dmem_cen", 32'(dmem_cen), 32'd1);
    chk("unc_dmem_addr", dmem_addr, 32'h100);
    chk("unc_m0_stall", 32'(m0_stall), 32'd0);
    chk("unc_owner", 32'(arb_owner), 32'd0);
    tick();
    m0_cen = 1'b0; m0_addr = 32'h0;
    settle();
    chk("idle_owner", 32'(arb_owner), 32'd0);
    chk("idle_dmem_cen", 32'(dmem_cen), 32'd0);
    chk("idle_dmem_addr", dmem_addr, 32'h0);
    tick();

    // Stalled m1 write holds the lock; m0 arrives during the stall.
    m1_cen = 1'b1; m1_wen = 1'b1; m1_strb = 4'hF; m1_addr = 32'h200; m1_wdata = 32'hDEADBEEF;
    dmem_stall = 1'b1; push1(32'h200, 1'b1);
    settle();
    chk("lockA_owner", 32'(arb_owner), 32'd0);
    chk("lockA_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("lockA_m1_stall", 32'(m1_stall), 32'd1);
    tick();
    m0_cen = 1'b1; m0_addr = 32'h300; push0(32'h300, 1'b0);
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("lock_owner", 32'(arb_owner), 32'd2);
      chk("lock_m0_stall", 32'(m0_stall), 32'd1);
      chk("lock_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("lock_strb", 32'(dmem_strb), 32'hF);
      chk("lock_wen", 32'(dmem_wen), 32'd1);
      tick();
    end
    dmem_stall = 1'b0; dmem_error = 1'b1;
    settle();
    chk("lockD_owner", 32'(arb_owner), 32'd2);
    chk("lockD_m0_stall", 32'(m0_stall), 32'd1);
    chk("lockD_m0_err", 32'(m0_error), 32'd0);
    chk("lockD_m1_err", 32'(m1_error), 32'd1);
    tick();
    m1_cen = 1'b0; m1_wen = 1'b0; m1_strb = 4'h0; m1_wdata = 32'h0; dmem_error = 1'b0;
    settle();
    chk("lockE_owner", 32'(arb_owner), 32'd0);
    chk("lockE_addr", dmem_addr, 32'h300);
    chk("lockE_m0_stall", 32'(m0_stall), 32'd0);
    tick();
    m0_cen = 1'b0;

    // Contention from NONE: m0 first, m1 the next cycle.
    m0_cen = 1'b1; m0_addr = 32'h400; push0(32'h400, 1'b0);
    m1_cen = 1'b1; m1_addr = 32'h500; push1(32'h500, 1'b0);
    settle();
    chk("cont_addr", dmem_addr, 32'h400);
    chk("cont_m1_stall", 32'(m1_stall), 32'd1);
    tick();
    m0_cen = 1'b0;
    settle();
    chk("cont2_addr", dmem_addr, 32'h500);
    chk("cont2_m1_stall", 32'(m1_stall), 32'd0);
    tick();
    m1_cen = 1'b0;

    // Back-to-back m0 with m1 waiting.
    m1_pend = 1'b1; m1_cen = 1'b1; m1_addr = 32'h700; push1(32'h700, 1'b0);
    a = 32'h800; m0_fresh = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m0_fresh) begin
        push0(a, 1'b0);
        m0_fresh = 1'b0;
      end
      m0_cen = 1'b1; m0_addr = a; m1_cen = m1_pend;
      settle();
      exp_m1 = m1_pend && FAIR && (i == WL);
      chk("starve_m1_grant", 32'(m1_cen && !m1_stall), 32'(exp_m1));
      chk("starve_addr", dmem_addr, exp_m1 ? 32'h700 : a);
      tick();
      if (exp_m1) begin
        m1_pend = 1'b0;
      end else begin
        a = a + 32'd4;
        m0_fresh = 1'b1;
      end
    end
`ifdef FRV_DMEM_ARB_FAIR_EN
    chk("starve_cnt_clear", 32'(dut.wait_cnt_reg), 32'd0);
`endif
    m0_cen = 1'b0; m1_cen = m1_pend;
    settle();
    chk("starve_release_m0_stall", 32'(m0_stall), 32'd0);
    tick();
    m1_cen = 1'b0;

    // Reset asserted mid-lock; pending m1 wins after release.
    m0_cen = 1'b1; m0_addr = 32'h900; dmem_stall = 1'b1;
    m1_cen = 1'b1; m1_addr = 32'hA00;
    settle();
    chk("rl_fwd_addr", dmem_addr, 32'h900);
    tick();
    settle();
    chk("rl_owner_lock0", 32'(arb_owner), 32'd1);
    g_resetn = 1'b0;
    #1;
    chk("rl_owner_rst", 32'(arb_owner), 32'd0);
    chk("rl_dmem_cen", 32'(dmem_cen), 32'd0);
    chk("rl_m0_stall", 32'(m0_stall), 32'd1);
    chk("rl_m1_stall", 32'(m1_stall), 32'd1);
    tick();
    g_resetn = 1'b1; m0_cen = 1'b0; dmem_stall = 1'b0; push1(32'hA00, 1'b0);
    settle();
    chk("rl_m1_addr", dmem_addr, 32'hA00);
    chk("rl_m1_stall_post", 32'(m1_stall), 32'd0);
    tick();
    m1_cen = 1'b0;
    tick();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frv_dmem_arbiter.md
# frv_dmem_arbiter

Two-master arbiter for the core's single data memory port. It sits between the backend pipeline's load/store unit (master 0) and a secondary requester such as a debug or DMA engine (master 1). It grants the port to one master at a time and holds the grant across stalled transactions. Master 0 has priority, and a configurable anti-starvation counter protects master 1.

## Interface
Parameters:
- WAIT_LIMIT, 4: master 0 completions tolerated while master 1 waits before master 1 is forced through. Legal range 1..15.

Ports:
- g_clk  in  1  global clock; one clock domain.
- g_resetn  in  1  reset; asynchronous, active-low.
- m0_cen, m1_cen  in  1 each  master chip enable (request).
- m0_wen, m1_wen  in  1 each  write enable.
- m0_strb, m1_strb  in  4 each  write strobe.
- m0_addr, m1_addr  in  32 each  address.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_stall, m1_stall  out  1 each  stall returned to the master.
- m0_error, m1_error  out  1 each  error returned to the master.
- m0_rdata, m1_rdata  out  32 each  read data returned to the master.
- dmem_cen, dmem_wen  out  1 each  forwarded request.
- dmem_strb  out  4  forwarded strobe.
- dmem_addr, dmem_wdata  out  32 each  forwarded address and write data.
- dmem_stall, dmem_error  in  1 each  port response.
- dmem_rdata  in  32  port read data.
- arb_owner  out  2  registered lock state: 00 none, 01 m0, 10 m1.

## Operation
Bus rule:
- A transaction completes on the cycle where cen=1 and stall=0. rdata and error are valid in that cycle only.
- A master must hold all request signals stable while it sees stall=1.

Lock states (registered owner): NONE, LOCK0, LOCK1.
- NONE: the winner is chosen combinationally in the same cycle.
  - Normal case: m0 wins if m0_cen; otherwise m1 if m1_cen.
  - Exception: if the starve flag is set (Configuration) and m1_cen, m1 wins.
  - If the winner sees dmem_stall=1, go to LOCK0 or LOCK1 respectively.
  - If the winner sees dmem_stall=0, the transaction completes and the state stays NONE.
- LOCKn: only master n is forwarded; no re-arbitration takes place.
  - Return to NONE on dmem_stall=0 while mn_cen=1 (completion).
  - Return to NONE if mn_cen drops. This is a protocol violation; the release is immediate and nothing is forwarded that cycle.

Forwarding:
- The granted master's request is muxed to dmem_*. With no grant, dmem_cen=0 and the other dmem_* outputs are 0.
- Granted master: mn_stall=dmem_stall and mn_error=dmem_error.
- Non-granted master: mn_stall=mn_cen and mn_error=0.
- dmem_rdata is broadcast to both m0_rdata and m1_rdata; it is meaningful only to the completing master.

## Timing
- Arbitration adds zero cycles of latency. An uncontended single-cycle access completes in the cycle it is presented.
- A losing master waits at least until the cycle after the winner completes.
- Back-to-back m0 accesses can therefore hold m1 off; the starve counter bounds this.
- Simultaneous m0_cen and m1_cen in NONE: m0 wins unless the starve flag is set.
- Reset (g_resetn low, any cycle including mid-lock):
  - Owner goes to NONE, counter goes to 0, arb_owner=00.
  - While reset is asserted: dmem_cen=0, m0_stall=m0_cen, m1_stall=m1_cen, m*_error=0.
  - The first cycle after deassertion arbitrates from NONE.
- An in-flight transaction aborted by reset is not replayed; the master re-requests.

## Configuration
- FRV_DMEM_ARB_FAIR_EN defined:
  - 4-bit counter wait_cnt increments on each m0 completion while m1_cen=1 and m1 is not granted.
  - It saturates at WAIT_LIMIT.
  - It clears on an m1 completion or on any cycle with m1_cen=0.
  - starve = (wait_cnt == WAIT_LIMIT).
- Not defined: the counter is absent, starve=0 permanently, and arbitration is strict m0 priority.

## Test plan
- Uncontended: m0 read at addr 0x100 with dmem_stall=0 -> dmem_cen=1 and dmem_addr=0x100 in the same cycle; m0_rdata=dmem_rdata; arb_owner stays 00.
- Stalled lock: m1 write 0xDEADBEEF with strb 0xF and dmem_stall=1 for 3 cycles; m0_cen raised in cycle 2 -> arb_owner=10 for 3 cycles, m0_stall=1 throughout, dmem_wdata holds 0xDEADBEEF; m0 is granted the cycle after m1 completes.
- Contention: both cen high from NONE with no stall -> m0 forwarded, m1_stall=1.
- Starvation (FAIR_EN, WAIT_LIMIT=4): m0 issues back-to-back single-cycle accesses with m1_cen held high -> m1 is granted on the 5th contended arbitration; wait_cnt returns to 0 after m1 completes. Without the macro, m1 is never granted while m0_cen stays high.
- Reset mid-lock: in LOCK0 with dmem_stall=1, pulse g_resetn low asynchronously -> arb_owner=00 and dmem_cen=0 immediately; after release, a pending m1 request is granted if m0_cen=0.
- Error routing: dmem_error=1 on an m1 completion -> m1_error=1, m0_error=0.
